// File: rtl/ans_table_loader.sv
// ans_table_loader
//   Loads a symbol-frequency table for the ANS decoder from a nibble stream.
//   It builds the inclusive cumulative table one symbol per cycle, then checks
//   it. The decoder is held in reset until the table is legal.
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   ena                  clock enable. Low freezes all state and forces in_rdy=0
//   load                 pulse that starts a (re)load. It wins over a coincident handshake
//   in/in_vld/in_rdy     count nibbles: symbol 0 first, LSB nibble of each count first
//   counts_unpacked      count[i] at [i*CNT_WIDTH +: CNT_WIDTH]
//   cumulative_unpacked  cum[i] = sum count[0..i] at [i*CUM_W +: CUM_W]
//   table_vld / err      table legal / last load had zero total or overflow
//   dec_rst_n            active-low decoder reset, high only while table_vld
module ans_table_loader #(
  parameter int SYM_WIDTH = 4,
  parameter int CNT_WIDTH = 4,
  parameter int SYM_COUNT = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       ena,
  input  logic                                       load,
  input  logic [SYM_WIDTH-1:0]                       in,
  input  logic                                       in_vld,
  output logic                                       in_rdy,
  output logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_unpacked,
  output logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
  output logic                                       table_vld,
  output logic                                       err,
  output logic                                       dec_rst_n
);
  localparam int CUM_W = CNT_WIDTH + SYM_WIDTH;
  localparam int NPC   = CNT_WIDTH / SYM_WIDTH;
  localparam int SP_W  = $clog2(SYM_COUNT);
  localparam int NIB_W = (NPC > 1) ? $clog2(NPC) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] ACCUM = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] READY = 3'd4;
  localparam logic [2:0] ERROR = 3'd5;

  localparam logic [SP_W-1:0] LAST = SP_W'(SYM_COUNT - 1);

  logic [2:0]                          state;
  logic [SP_W-1:0]                     sym_ptr;
  logic [NIB_W-1:0]                    nib_ptr;
  logic [CUM_W:0]                      acc, acc_next;
  logic                                ovf;
  logic [SYM_COUNT-1:0][CNT_WIDTH-1:0] cnt;
  logic [SYM_COUNT-1:0][CUM_W-1:0]     cum;

  assign in_rdy              = (state == LOAD) && ena;
  assign counts_unpacked     = cnt;
  assign cumulative_unpacked = cum;
  // acc carries one extra bit so a carry out of CUM_W is seen as overflow
  assign acc_next            = acc + (CUM_W+1)'(cnt[sym_ptr]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sym_ptr   <= '0;
      nib_ptr   <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      cum       <= '0;
      table_vld <= 1'b0;
      err       <= 1'b0;
      dec_rst_n <= 1'b0;
    end else if (ena) begin
      if (load) begin
        state     <= LOAD;
        sym_ptr   <= '0;
        nib_ptr   <= '0;
        table_vld <= 1'b0;
        err       <= 1'b0;
        dec_rst_n <= 1'b0;
      end else begin
        case (state)
          LOAD: if (in_vld) begin
            for (int n = 0; n < NPC; n++)
              if (nib_ptr == NIB_W'(n)) cnt[sym_ptr][n*SYM_WIDTH +: SYM_WIDTH] <= in;
            if (nib_ptr == NIB_W'(NPC - 1)) begin
              nib_ptr <= '0;
              if (sym_ptr == LAST) begin
                state   <= ACCUM;
                sym_ptr <= '0;
                acc     <= '0;
                ovf     <= 1'b0;
              end else begin
                sym_ptr <= sym_ptr + SP_W'(1);
              end
            end else begin
              nib_ptr <= nib_ptr + NIB_W'(1);
            end
          end
          ACCUM: begin
            acc          <= acc_next;
            cum[sym_ptr] <= acc_next[CUM_W-1:0];
            if (acc_next[CUM_W]) ovf <= 1'b1;
            if (sym_ptr == LAST) begin
              state   <= CHECK;
              sym_ptr <= '0;
            end else begin
              sym_ptr <= sym_ptr + SP_W'(1);
            end
          end
          CHECK: begin
            if (ovf || cum[LAST] == '0) begin
              state <= ERROR;
              err   <= 1'b1;
            end else begin
              state     <= READY;
              table_vld <= 1'b1;
              dec_rst_n <= 1'b1;
            end
          end
          default: ; // IDLE/READY/ERROR hold until load
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ans_table_loader.sv
module tb_ans_table_loader;
  localparam int SW = 4, CW = 4, SC = 16, CUMW = CW + SW, NPC = CW / SW;

  logic clk = 0, rst = 1, ena = 0, load = 0, in_vld = 0;
  logic [SW-1:0] din = '0;
  logic in_rdy, table_vld, err, dec_rst_n;
  logic [CW*SC-1:0]   counts;
  logic [CUMW*SC-1:0] cums;

  always #5 clk = ~clk;

  ans_table_loader #(.SYM_WIDTH(SW), .CNT_WIDTH(CW), .SYM_COUNT(SC)) dut (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .in(din), .in_vld(in_vld),
    .in_rdy(in_rdy), .counts_unpacked(counts), .cumulative_unpacked(cums),
    .table_vld(table_vld), .err(err), .dec_rst_n(dec_rst_n));

  int vecs = 0, errs = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 idle, 1 collecting nibbles, 2 busy
  // (countdown to verdict), 3 ready, 4 error.
  int m_phase = 0, m_k = 0, m_wait = 0;
  int m_cnt[SC];

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_phase = 0; m_k = 0; m_wait = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
      end else if (ena) begin
        if (load) begin
          m_phase = 1; m_k = 0;
        end else if (m_phase == 1 && in_vld) begin
          int s, sh;
          s  = m_k / NPC;
          sh = (m_k % NPC) * SW;
          m_cnt[s] = (m_cnt[s] & ~(((1 << SW) - 1) << sh)) | (int'(din) << sh);
          m_k++;
          if (m_k == SC * NPC) begin m_phase = 2; m_wait = SC + 1; end
        end else if (m_phase == 2) begin
          m_wait--;
          if (m_wait == 0) begin
            int sum;
            sum = 0;
            foreach (m_cnt[i]) sum += m_cnt[i];
            m_phase = (sum == 0 || sum >= (1 << CUMW)) ? 4 : 3;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    logic [CW*SC-1:0]   ec;
    logic [CUMW*SC-1:0] eu;
    int run;
    @(negedge clk);
    ec = '0; eu = '0; run = 0;
    for (int i = 0; i < SC; i++) begin
      run += m_cnt[i];
      ec[i*CW +: CW]     = CW'(m_cnt[i]);
      eu[i*CUMW +: CUMW] = CUMW'(run);
    end
    chk("in_rdy", in_rdy, (m_phase == 1) && ena);
    chk("table_vld", table_vld, m_phase == 3);
    chk("err", err, m_phase == 4);
    chk("dec_rst_n", dec_rst_n, m_phase == 3);
    if (m_phase == 0) begin
      chk("idle_counts", counts, 0);
      chk("idle_cum", cums, 0);
    end else if (m_phase >= 3) begin
      chk("counts", counts, ec);
      chk("cum", cums, eu);
    end
  end

  task automatic pulse_load();
    @(negedge clk); load = 1;
    @(negedge clk); load = 0;
  endtask

  task automatic send_nib(input logic [SW-1:0] v, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    din = v; in_vld = 1; t = 0;
    while (!in_rdy && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin vecs++; errs++; $display("FAIL send_timeout: got no in_rdy want in_rdy"); end
    @(negedge clk);
    in_vld = 0;
  endtask

  task automatic send_range(input logic [CW-1:0] tbl[SC], input int lo, input int hi, input bit gaps);
    for (int i = lo; i < hi; i++)
      for (int n = 0; n < NPC; n++) send_nib(SW'(tbl[i] >> (n * SW)), gaps);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(table_vld || err) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin vecs++; errs++; $display("FAIL done_timeout: got no verdict want verdict"); end
  endtask

  logic [CW-1:0] ones[SC], t2[SC], zeros[SC], fresh[SC];

  initial begin
    int n;
    foreach (ones[i]) begin
      ones[i] = 1; zeros[i] = 0; fresh[i] = CW'(15 - i); t2[i] = 0;
    end
    t2[0] = 8; t2[1] = 4; t2[2] = 2; t2[3] = 1; t2[4] = 1;

    ena = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", table_vld, 0);
    chk("rst_dec", dec_rst_n, 0);
    #2 rst = 0;
    @(negedge clk);
    chk("idle_rdy", in_rdy, 0);

    // 1: all ones, latency from final accepting edge
    pulse_load();
    send_range(ones, 0, SC, 0);
    n = 0;
    while (!table_vld && n < 100) begin @(posedge clk); #1; n++; end
    chk("t1_latency", n, 17);
    chk("t1_cum0", cums[0 +: CUMW], 1);
    chk("t1_cum15", cums[15*CUMW +: CUMW], 16);
    chk("t1_dec", dec_rst_n, 1);
    chk("t1_err", err, 0);

    // 2: skewed table
    pulse_load();
    send_range(t2, 0, SC, 0);
    wait_done();
    chk("t2_cum1", cums[1*CUMW +: CUMW], 12);
    chk("t2_cum3", cums[3*CUMW +: CUMW], 15);
    chk("t2_cum4", cums[4*CUMW +: CUMW], 16);
    chk("t2_cum15", cums[15*CUMW +: CUMW], 16);

    // 3: zero table errors, then reload recovers
    pulse_load();
    send_range(zeros, 0, SC, 0);
    wait_done();
    @(negedge clk);
    chk("t3_err", err, 1);
    chk("t3_vld", table_vld, 0);
    chk("t3_dec", dec_rst_n, 0);
    pulse_load();
    chk("t3_err_clr", err, 0);
    send_range(ones, 0, SC, 0);
    wait_done();
    chk("t3_reload", table_vld, 1);

    // 4: abort after 7 nibbles with load coincident with a handshake
    pulse_load();
    for (int i = 0; i < 7; i++) send_nib(4'hF, 0);
    din = 4'hF; in_vld = 1; load = 1;
    @(negedge clk);
    load = 0; in_vld = 0;
    send_range(fresh, 0, SC, 0);
    wait_done();
    chk("t4_cnt0", counts[0 +: CW], 15);
    chk("t4_cum0", cums[0 +: CUMW], 15);
    chk("t4_cum15", cums[15*CUMW +: CUMW], 120);

    // 5: random in_vld gaps, ena low mid-LOAD and mid-ACCUM
    pulse_load();
    send_range(ones, 0, 8, 1);
    ena = 0; din = 4'hA; in_vld = 1;
    repeat (5) begin @(negedge clk); chk("t5_rdy_off", in_rdy, 0); end
    ena = 1; in_vld = 0;
    send_range(ones, 8, SC, 1);
    repeat (4) @(negedge clk);
    ena = 0;
    repeat (5) @(negedge clk);
    chk("t5_stall", table_vld, 0);
    ena = 1;
    wait_done();
    chk("t5_cum15", cums[15*CUMW +: CUMW], 16);

    // 6: reset during ACCUM
    pulse_load();
    send_range(ones, 0, SC, 0);
    repeat (5) @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("t6_vld", table_vld, 0);
    chk("t6_counts", counts, 0);
    chk("t6_cum", cums, 0);
    repeat (3) begin @(negedge clk); chk("t6_rdy", in_rdy, 0); end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
